instruction_encoder_loader: RTL

INSTRUCTION_ENCODER_LOADER -- requirements
Module: instruction_encoder_loader

---
 rtl/instruction_encoder_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/instruction_encoder_loader.sv
// Encodes MIPS-style instruction descriptors into 32-bit words, buffers them in a small FIFO
// and streams them into instruction memory from a programmable base address.
module instruction_encoder_loader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clockMachine,
    input  logic                  resetMachine,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [2:0]            inClass,
    input  logic [4:0]            inRs,
    input  logic [4:0]            inRt,
    input  logic [4:0]            inRd,
    input  logic [5:0]            inFunct,
    input  logic [15:0]           inImmediate,
    input  logic [25:0]           inTarget,
    input  logic                  inLast,
    input  logic                  startLoad,
    input  logic [ADDR_WIDTH-1:0] baseAddress,
    input  logic                  memReady,
    output logic                  writeEnableInstructionMemory,
    output logic [ADDR_WIDTH-1:0] writeAddressInstructionMemory,
    output logic [31:0]           writeDataInstructionMemory,
    output logic                  busy,
    output logic                  loadDone,
    output logic                  errorInvalidClass
);

    localparam int unsigned PtrWidth = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrWidth:0] FullCount = (PtrWidth + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    error_q;
    logic [31:0]             fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_q;
    logic [PtrWidth-1:0]     wr_ptr_q;
    logic [PtrWidth-1:0]     rd_ptr_q;
    logic [PtrWidth:0]       count_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;

    assign fifo_full  = (count_q == FullCount);
    assign fifo_empty = (count_q == '0);
    assign push       = inValid && !fifo_full;
    assign pop        = (state_q == StLoad) && !fifo_empty && memReady;

    // Class 7 falls through to the default and becomes a NOP.
    always_comb begin
        enc_word = 32'h0000_0000;
        case (inClass)
            3'd0:    enc_word = {6'b000000, inRs, inRt, inRd, 5'b00000, inFunct};
            3'd1:    enc_word = {6'b001000, inRs, inRt, inImmediate};
            3'd2:    enc_word = {6'b100011, inRs, inRt, inImmediate};
            3'd3:    enc_word = {6'b101011, inRs, inRt, inImmediate};
            3'd4:    enc_word = {6'b000010, inTarget};
            3'd5:    enc_word = {6'b000100, inRs, inRt, inImmediate};
            3'd6:    enc_word = {6'b001101, inRs, inRt, inImmediate};
            default: enc_word = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clockMachine) begin
        if (resetMachine) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            error_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= enc_word;
                fifo_last_q[wr_ptr_q] <= inLast;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
                if (inClass == 3'd7) begin
                    error_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            case (state_q)
                StIdle: begin
                    if (startLoad) begin
                        state_q <= StLoad;
                        addr_q  <= baseAddress;
                    end
                end
                StLoad: begin
                    if (pop) begin
                        addr_q <= addr_q + 1'b1;
                        if (fifo_last_q[rd_ptr_q]) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decode registered state only, so they are stable for the whole cycle.
    always_comb begin
        inReady                       = !fifo_full;
        writeEnableInstructionMemory  = (state_q == StLoad) && !fifo_empty;
        writeAddressInstructionMemory = addr_q;
        writeDataInstructionMemory    = writeEnableInstructionMemory ? fifo_data_q[rd_ptr_q]
                                                                     : 32'h0000_0000;
        busy                          = (state_q == StLoad);
        loadDone                      = (state_q == StDone);
        errorInvalidClass             = error_q;
    end

endmodule
